// File: rtl/multicycle_control.sv
// Multicycle processor control unit: sequences fetch/decode/execute/memory/writeback
// with a memory handshake, flags unsupported opcodes and counts retired instructions.
module multicycle_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        mem_ready,
  output logic        InstrFetch,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        Branch,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic [1:0]  ALUOp,
  output logic [3:0]  state,
  output logic        illegal,
  output logic        retire,
  output logic [31:0] retired_count
);

  // state  | meaning
  // FETCH  | read instruction memory, load IR and PC+4 on mem_ready
  // DECODE | classify opcode, branch to the class-specific path
  // ADDR   | compute load/store effective address
  // MEM_RD | data memory read, wait for mem_ready
  // MEM_WR | data memory write, wait for mem_ready, retire store
  // WB_MEM | write loaded data to register file, retire load
  // EXEC_R | R-type ALU operation
  // WB_ALU | write ALU result to register file, retire R-type
  // BRANCH | branch compare and PC update, retire branch
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ADDR   = 4'd2,
    S_MEM_RD = 4'd3,
    S_MEM_WR = 4'd4,
    S_WB_MEM = 4'd5,
    S_EXEC_R = 4'd6,
    S_WB_ALU = 4'd7,
    S_BRANCH = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    C_R       = 3'd0,
    C_LOAD    = 3'd1,
    C_STORE   = 3'd2,
    C_BR      = 3'd3,
    C_ILLEGAL = 3'd4
  } class_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  state_e      state_q, state_d;
  class_e      class_q, class_d;
  class_e      class_dec;
  logic [31:0] retired_count_q, retired_count_d;

  // Only the opcode field steers sequencing; the rest belongs to the datapath.
  logic unused_instr;
  assign unused_instr = ^instruction[31:7];

  always_comb begin
    class_dec = C_ILLEGAL;
    case (instruction[6:0])
      OP_R:     class_dec = C_R;
      OP_LOAD:  class_dec = C_LOAD;
      OP_STORE: class_dec = C_STORE;
      OP_BR:    class_dec = C_BR;
      default:  class_dec = C_ILLEGAL;
    endcase
  end

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        class_d = class_dec;
        case (class_dec)
          C_R:             state_d = S_EXEC_R;
          C_LOAD, C_STORE: state_d = S_ADDR;
          C_BR:            state_d = S_BRANCH;
          default:         state_d = S_FETCH;
        endcase
      end
      S_ADDR: begin
        state_d = (class_q == C_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        if (mem_ready) state_d = S_FETCH;
      end
      S_WB_MEM: state_d = S_FETCH;
      S_EXEC_R: state_d = S_WB_ALU;
      S_WB_ALU: state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Outputs follow the current state; the handshake-qualified strobes are
  // additionally gated by mem_ready, and everything is held low during reset.
  always_comb begin
    InstrFetch = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    Branch     = 1'b0;
    ALUSrc     = 1'b0;
    RegWrite   = 1'b0;
    ALUOp      = 2'b00;
    illegal    = 1'b0;
    retire     = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          InstrFetch = 1'b1;
          MemRead    = 1'b1;
          IRWrite    = mem_ready;
          PCWrite    = mem_ready;
        end
        S_DECODE: begin
          illegal = (class_dec == C_ILLEGAL);
        end
        S_ADDR: begin
          ALUSrc = 1'b1;
          ALUOp  = 2'b00;
        end
        S_MEM_RD: begin
          ALUSrc  = 1'b1;
          MemRead = 1'b1;
        end
        S_MEM_WR: begin
          ALUSrc   = 1'b1;
          MemWrite = 1'b1;
          retire   = mem_ready;
        end
        S_WB_MEM: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
          retire   = 1'b1;
        end
        S_EXEC_R: begin
          ALUOp = 2'b10;
        end
        S_WB_ALU: begin
          ALUOp    = 2'b10;
          RegWrite = 1'b1;
          retire   = 1'b1;
        end
        S_BRANCH: begin
          Branch = 1'b1;
          ALUOp  = 2'b01;
          retire = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    retired_count_d = retired_count_q;
    if (retire) retired_count_d = retired_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_FETCH;
      class_q         <= C_ILLEGAL;
      retired_count_q <= 32'd0;
    end else begin
      state_q         <= state_d;
      class_q         <= class_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign state         = state_q;
  assign retired_count = retired_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: hand-computed state/control sequences
// for R, load, store, branch, illegal, reset-during-wait and counter wrap.
module tb_multicycle_control;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic        mem_ready;
  logic        InstrFetch, IRWrite, PCWrite, MemRead, MemWrite, MemtoReg;
  logic        Branch, ALUSrc, RegWrite, illegal, retire;
  logic [1:0]  ALUOp;
  logic [3:0]  state;
  logic [31:0] retired_count;

  int tests = 0;
  int fails = 0;

  multicycle_control dut (
    .clk           (clk),
    .rst           (rst),
    .instruction   (instruction),
    .mem_ready     (mem_ready),
    .InstrFetch    (InstrFetch),
    .IRWrite       (IRWrite),
    .PCWrite       (PCWrite),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .MemtoReg      (MemtoReg),
    .Branch        (Branch),
    .ALUSrc        (ALUSrc),
    .RegWrite      (RegWrite),
    .ALUOp         (ALUOp),
    .state         (state),
    .illegal       (illegal),
    .retire        (retire),
    .retired_count (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {InstrFetch,IRWrite,PCWrite,MemRead,MemWrite,MemtoReg,Branch,ALUSrc,RegWrite,ALUOp,illegal,retire}
  localparam logic [12:0] K_ZERO  = 13'b0_0_0_0_0_0_0_0_0_00_0_0;
  localparam logic [12:0] K_F_W   = 13'b1_0_0_1_0_0_0_0_0_00_0_0;
  localparam logic [12:0] K_F_R   = 13'b1_1_1_1_0_0_0_0_0_00_0_0;
  localparam logic [12:0] K_DEC   = 13'b0_0_0_0_0_0_0_0_0_00_0_0;
  localparam logic [12:0] K_DEC_I = 13'b0_0_0_0_0_0_0_0_0_00_1_0;
  localparam logic [12:0] K_ADDR  = 13'b0_0_0_0_0_0_0_1_0_00_0_0;
  localparam logic [12:0] K_MRD   = 13'b0_0_0_1_0_0_0_1_0_00_0_0;
  localparam logic [12:0] K_MWR_W = 13'b0_0_0_0_1_0_0_1_0_00_0_0;
  localparam logic [12:0] K_MWR_R = 13'b0_0_0_0_1_0_0_1_0_00_0_1;
  localparam logic [12:0] K_WBM   = 13'b0_0_0_0_0_1_0_0_1_00_0_1;
  localparam logic [12:0] K_EXR   = 13'b0_0_0_0_0_0_0_0_0_10_0_0;
  localparam logic [12:0] K_WBA   = 13'b0_0_0_0_0_0_0_0_1_10_0_1;
  localparam logic [12:0] K_BRN   = 13'b0_0_0_0_0_0_1_0_0_01_0_1;

  logic [12:0] ctl;
  assign ctl = {InstrFetch, IRWrite, PCWrite, MemRead, MemWrite, MemtoReg,
                Branch, ALUSrc, RegWrite, ALUOp, illegal, retire};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check state and controls mid-cycle, then advance just past the next edge.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [12:0] exp_ctl);
    @(negedge clk);
    chk({tag, " state"}, {28'd0, state}, {28'd0, st});
    chk({tag, " ctl"}, {19'd0, ctl}, {19'd0, exp_ctl});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    mem_ready   = 1'b1;
    instruction = 32'h0;
    @(posedge clk);
    #1;
    cyc("reset", 4'd0, K_ZERO);
    chk("reset count", retired_count, 32'd0);
    rst = 1'b0;

    // add: 0,1,6,7
    instruction = 32'h0020_8033;
    cyc("add fetch", 4'd0, K_F_R);
    cyc("add decode", 4'd1, K_DEC);
    cyc("add exec", 4'd6, K_EXR);
    cyc("add wb", 4'd7, K_WBA);
    chk("add count", retired_count, 32'd1);

    // lw with 2 wait cycles in MEM_RD; opcode scrambled after DECODE
    instruction = 32'h0000_A103;
    cyc("lw fetch", 4'd0, K_F_R);
    cyc("lw decode", 4'd1, K_DEC);
    instruction = 32'h0000_007F;
    mem_ready   = 1'b0;
    cyc("lw addr", 4'd2, K_ADDR);
    cyc("lw mrd w1", 4'd3, K_MRD);
    cyc("lw mrd w2", 4'd3, K_MRD);
    mem_ready = 1'b1;
    cyc("lw mrd rdy", 4'd3, K_MRD);
    cyc("lw wb", 4'd5, K_WBM);
    chk("lw count", retired_count, 32'd2);

    // sw with 3 wait cycles in FETCH and one in MEM_WR
    instruction = 32'h0020_A023;
    mem_ready   = 1'b0;
    cyc("sw fetch w1", 4'd0, K_F_W);
    cyc("sw fetch w2", 4'd0, K_F_W);
    cyc("sw fetch w3", 4'd0, K_F_W);
    mem_ready = 1'b1;
    cyc("sw fetch rdy", 4'd0, K_F_R);
    cyc("sw decode", 4'd1, K_DEC);
    cyc("sw addr", 4'd2, K_ADDR);
    mem_ready = 1'b0;
    cyc("sw mwr w", 4'd4, K_MWR_W);
    chk("sw count mid", retired_count, 32'd2);
    mem_ready = 1'b1;
    cyc("sw mwr rdy", 4'd4, K_MWR_R);
    chk("sw count", retired_count, 32'd3);

    // beq then an illegal opcode
    instruction = 32'h0020_8063;
    cyc("beq fetch", 4'd0, K_F_R);
    cyc("beq decode", 4'd1, K_DEC);
    cyc("beq branch", 4'd8, K_BRN);
    chk("beq count", retired_count, 32'd4);
    instruction = 32'h0000_007F;
    cyc("ill fetch", 4'd0, K_F_R);
    cyc("ill decode", 4'd1, K_DEC_I);
    chk("ill count", retired_count, 32'd4);

    // lw interrupted by reset during the MEM_RD wait
    instruction = 32'h0000_A103;
    cyc("ill next fetch", 4'd0, K_F_R);
    cyc("rlw decode", 4'd1, K_DEC);
    mem_ready = 1'b0;
    cyc("rlw addr", 4'd2, K_ADDR);
    cyc("rlw mrd w", 4'd3, K_MRD);
    rst = 1'b1;
    cyc("rlw mrd rst", 4'd3, K_ZERO);
    rst = 1'b0;
    chk("rlw count", retired_count, 32'd0);
    cyc("rlw fetch", 4'd0, K_F_W);

    // counter wrap: preload two below the top, then retire two branches
    force dut.retired_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.retired_count_q;
    chk("wrap preload", retired_count, 32'hFFFF_FFFE);
    mem_ready   = 1'b1;
    instruction = 32'h0020_8063;
    cyc("wrap1 fetch", 4'd0, K_F_R);
    cyc("wrap1 decode", 4'd1, K_DEC);
    cyc("wrap1 branch", 4'd8, K_BRN);
    chk("wrap1 count", retired_count, 32'hFFFF_FFFF);
    cyc("wrap2 fetch", 4'd0, K_F_R);
    cyc("wrap2 decode", 4'd1, K_DEC);
    cyc("wrap2 branch", 4'd8, K_BRN);
    chk("wrap2 count", retired_count, 32'h0000_0000);
    cyc("wrap end fetch", 4'd0, K_F_R);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
